// File: rtl/mac_dot_seq_pkg.sv
// Shared types for the MAC dot-product sequencer: controller states and a
// width-generic two's complement add with optional clamping.
package mac_dot_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  localparam int SUM_W = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [SUM_W-1:0] sum;
  } sat_res_t;

  // Operands arrive sign-extended from w bits, so the wide add never overflows.
  // The caller keeps the low w bits; with en=0 that is plain wrap-around.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input int unsigned w,
                                       input logic en);
    sat_res_t r;
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.ovf = 1'b0;
    r.sum = s;
    if (en) begin
      if (s > hi) begin
        r.ovf = 1'b1;
        r.sum = hi;
      end else if (s < lo) begin
        r.ovf = 1'b1;
        r.sum = lo;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Operand, multiplier and result signals between the MAC sequencer and the
// blocks around it. The sequencer takes the slave side.
interface mac_dot_seq_if #(
  parameter int N     = 8,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     x_in;
  logic [N-1:0]     mult_a;
  logic [N-1:0]     mult_x;
  logic [N-1:0]     mult_ax;
  logic [N-1:0]     acc_out;
  logic             sat_flag;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  start, len, in_valid, a_in, x_in, mult_ax, out_ready,
    output in_ready, mult_a, mult_x, acc_out, sat_flag, out_valid, busy
  );

  modport master (
    output start, len, in_valid, a_in, x_in, mult_ax, out_ready,
    input  in_ready, mult_a, mult_x, acc_out, sat_flag, out_valid, busy
  );
endinterface

// File: rtl/mac_dot_seq_pipe.sv
// Two-stage operand/product pipeline feeding the accumulator. Stage 1 drives
// the external multiplier directly; stage 2 captures its product.
module mac_dot_pipe
  import mac_dot_seq_pkg::*;
#(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         accept,
  input  logic         last_in,
  input  logic         clear,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] mult_ax,
  output logic [N-1:0] mult_a,
  output logic [N-1:0] mult_x,
  output logic [N-1:0] acc,
  output logic         sat_flag,
  output logic         s2_v,
  output logic         s2_last
);

  logic               s1_v;
  logic               s1_last;
  logic [N-1:0]       prod;
  sat_res_t           acc_sum;
  logic [SUM_W-N-1:0] sum_ext_unused;

  always_comb begin
    acc_sum = sat_add({{(SUM_W-N){acc[N-1]}}, acc},
                      {{(SUM_W-N){prod[N-1]}}, prod}, N, SAT);
  end

  assign sum_ext_unused = acc_sum.sum[SUM_W-1:N];

  // Operands hold between accepts so the multiplier input stays quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a  <= '0;
      mult_x  <= '0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_v    <= accept;
      s1_last <= accept & last_in;
      if (accept) begin
        mult_a <= a_in;
        mult_x <= x_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod    <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      prod    <= mult_ax;
      s2_v    <= s1_v;
      s2_last <= s1_last;
    end
  end

  // clear only fires in IDLE, when the pipeline is already empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (s2_v) begin
      acc      <= acc_sum.sum[N-1:0];
      sat_flag <= sat_flag | acc_sum.ovf;
    end
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product job controller: counts beats into the shared multiplier
// pipeline and hands the accumulated result to the consumer.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mac_dot_seq_if.slave bus
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic             accept;
  logic             clear;
  logic             last_beat;
  logic             s2_v;
  logic             s2_last;

  assign last_beat = (cnt_q == ONE);
  assign bus.busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // WAIT lets the final beat drain through both stages before DONE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clear         = 1'b0;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear = 1'b1;
          if (bus.len != '0) begin
            state_d = RUN;
            cnt_d   = bus.len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (accept) begin
          cnt_d = cnt_q - ONE;
          if (last_beat) state_d = WAIT;
        end
      end
      WAIT: begin
        if (s2_v && s2_last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mac_dot_pipe #(
    .N   (N),
    .SAT (SAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .last_in  (last_beat),
    .clear    (clear),
    .a_in     (bus.a_in),
    .x_in     (bus.x_in),
    .mult_ax  (bus.mult_ax),
    .mult_a   (bus.mult_a),
    .mult_x   (bus.mult_x),
    .acc      (bus.acc_out),
    .sat_flag (bus.sat_flag),
    .s2_v     (s2_v),
    .s2_last  (s2_last)
  );

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: a saturating and a wrapping instance share stimulus;
// results are checked against a scoreboard filled when each job is started.
module tb_mac_dot_seq;

  localparam int N     = 8;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [7:0] acc_sat;
    logic       flag;
    logic [7:0] acc_wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   use_real = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cnt = 0;
  int   acc_base = 0;
  int   first_acc = -1;
  int   last_acc = -1;
  bit   ready_seen = 1'b0;

  logic [7:0] pair_a[$];
  logic [7:0] pair_x[$];
  bit         vpat[$];
  exp_t       exp_q[$];
  exp_t       e;

  mac_dot_seq_if #(.N(N), .LEN_W(LEN_W)) bus_s ();
  mac_dot_seq_if #(.N(N), .LEN_W(LEN_W)) bus_w ();

  mac_dot_seq #(.N(N), .LEN_W(LEN_W), .SAT(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  mac_dot_seq #(.N(N), .LEN_W(LEN_W), .SAT(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  always #5 clk = ~clk;

  // Sign-magnitude Q1.7 multiplier reference: |a|*|x| >> 7, then signed.
  function automatic logic [7:0] mult_model(input logic [7:0] a, input logic [7:0] x);
    int sa, sx, ma, mx, p;
    logic [31:0] pv;
    sa = int'($signed(a));
    sx = int'($signed(x));
    ma = (sa < 0) ? -sa : sa;
    mx = (sx < 0) ? -sx : sx;
    p  = (ma * mx) >>> 7;
    if ((sa < 0) != (sx < 0)) p = -p;
    pv = p;
    return pv[7:0];
  endfunction

  function automatic logic [7:0] product(input logic [7:0] a, input logic [7:0] x, input bit real_m);
    logic [7:0] s;
    s = a + x;
    return real_m ? mult_model(a, x) : s;
  endfunction

  function automatic exp_t golden(input int n);
    exp_t r;
    int s_acc, w_acc, p;
    bit f;
    logic [31:0] sv, wv;
    s_acc = 0;
    w_acc = 0;
    f = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = int'($signed(product(pair_a[i], pair_x[i], use_real)));
      s_acc += p;
      if (s_acc > 127) begin
        s_acc = 127;
        f = 1'b1;
      end else if (s_acc < -128) begin
        s_acc = -128;
        f = 1'b1;
      end
      w_acc += p;
    end
    sv = s_acc;
    wv = w_acc;
    r.acc_sat  = sv[7:0];
    r.flag     = f;
    r.acc_wrap = wv[7:0];
    return r;
  endfunction

  assign bus_s.mult_ax   = product(bus_s.mult_a, bus_s.mult_x, use_real);
  assign bus_w.mult_ax   = product(bus_w.mult_a, bus_w.mult_x, use_real);
  assign bus_w.start     = bus_s.start;
  assign bus_w.len       = bus_s.len;
  assign bus_w.in_valid  = bus_s.in_valid;
  assign bus_w.a_in      = bus_s.a_in;
  assign bus_w.x_in      = bus_s.x_in;
  assign bus_w.out_ready = bus_s.out_ready;

  // Observes accepted beats and their edge numbers independently of the driver.
  always @(posedge clk) begin
    cyc++;
    if (bus_s.in_valid && bus_s.in_ready) begin
      accept_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (bus_s.in_ready) ready_seen = 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic start_job(input int n);
    exp_q.push_back(golden(n));
    acc_base   = accept_cnt;
    first_acc  = -1;
    last_acc   = -1;
    ready_seen = 1'b0;
    @(negedge clk);
    bus_s.start = 1'b1;
    bus_s.len   = LEN_W'(n);
    @(negedge clk);
    bus_s.start = 1'b0;
    bus_s.len   = '0;
  endtask

  task automatic apply_stimulus(input int max_acc, input int glitch_step);
    int idx, step;
    bit will;
    idx  = 0;
    step = 0;
    while (idx < max_acc && step < 200) begin
      bus_s.in_valid = (vpat.size() == 0) ? 1'b1 : vpat[step % vpat.size()];
      bus_s.a_in     = pair_a[idx];
      bus_s.x_in     = pair_x[idx];
      bus_s.start    = (step == glitch_step);
      bus_s.len      = (step == glitch_step) ? LEN_W'(9) : '0;
      will = bus_s.in_valid && bus_s.in_ready;
      @(negedge clk);
      step++;
      if (will) idx++;
    end
    bus_s.in_valid = 1'b0;
    bus_s.start    = 1'b0;
    bus_s.len      = '0;
    if (idx < max_acc) check_output("feed_timeout", idx, max_acc);
  endtask

  task automatic wait_result(input string tag, output exp_t r);
    int waited;
    waited = 0;
    while (!bus_s.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, "_valid"}, bus_s.out_valid, 1);
    check_output({tag, "_wrap_valid"}, bus_w.out_valid, 1);
    if (exp_q.size() == 0) begin
      check_output({tag, "_sb_empty"}, 0, 1);
      r = '0;
    end else begin
      r = exp_q.pop_front();
      check_output({tag, "_acc"}, bus_s.acc_out, r.acc_sat);
      check_output({tag, "_flag"}, bus_s.sat_flag, r.flag);
      check_output({tag, "_wrap_acc"}, bus_w.acc_out, r.acc_wrap);
      check_output({tag, "_wrap_flag"}, bus_w.sat_flag, 0);
    end
  endtask

  task automatic finish_result(input string tag, input int hold, input logic [7:0] exp_acc, input bit start_too);
    for (int i = 0; i < hold; i++) begin
      check_output({tag, "_hold_valid"}, bus_s.out_valid, 1);
      check_output({tag, "_hold_acc"}, bus_s.acc_out, exp_acc);
      @(negedge clk);
    end
    bus_s.out_ready = 1'b1;
    bus_s.start     = start_too;
    bus_s.len       = start_too ? LEN_W'(3) : '0;
    @(negedge clk);
    bus_s.out_ready = 1'b0;
    bus_s.start     = 1'b0;
    bus_s.len       = '0;
    check_output({tag, "_idle_busy"}, bus_s.busy, 0);
    check_output({tag, "_idle_valid"}, bus_s.out_valid, 0);
  endtask

  initial begin
    int v;
    bus_s.start     = 1'b0;
    bus_s.len       = '0;
    bus_s.in_valid  = 1'b0;
    bus_s.a_in      = '0;
    bus_s.x_in      = '0;
    bus_s.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_in_ready", bus_s.in_ready, 0);
    check_output("rst_out_valid", bus_s.out_valid, 0);
    check_output("rst_busy", bus_s.busy, 0);
    check_output("rst_acc", bus_s.acc_out, 0);
    check_output("rst_sat", bus_s.sat_flag, 0);
    check_output("rst_mult_a", bus_s.mult_a, 0);
    check_output("rst_mult_x", bus_s.mult_x, 0);
    rst = 1'b0;

    $display("[TB] basic job");
    pair_a = '{8'd1, 8'd3, 8'd5};
    pair_x = '{8'd2, 8'd4, 8'd6};
    start_job(3);
    check_output("t1_busy", bus_s.busy, 1);
    apply_stimulus(3, -1);
    check_output("t1_accepts", accept_cnt - acc_base, 3);
    check_output("t1_consecutive", last_acc - first_acc, 2);
    wait_result("t1", e);
    check_output("t1_latency", cyc - last_acc, 2);
    check_output("t1_const", bus_s.acc_out, 21);
    finish_result("t1", 0, e.acc_sat, 1'b0);

    $display("[TB] stalls and backpressure");
    pair_a = '{8'd1, 8'd2, 8'hFD, 8'd10};
    pair_x = '{8'd1, 8'd2, 8'd1, 8'hEC};
    vpat   = '{1, 0, 0, 1, 1, 0, 1};
    start_job(4);
    apply_stimulus(4, -1);
    vpat.delete();
    check_output("t2_accepts", accept_cnt - acc_base, 4);
    wait_result("t2", e);
    finish_result("t2", 5, e.acc_sat, 1'b0);

    $display("[TB] saturation and wrap");
    pair_a = '{8'h40, 8'h40};
    pair_x = '{8'h30, 8'h30};
    start_job(2);
    apply_stimulus(2, -1);
    wait_result("t3", e);
    check_output("t3_sat_const", bus_s.acc_out, 8'h7F);
    check_output("t3_wrap_const", bus_w.acc_out, 8'hE0);
    finish_result("t3", 0, e.acc_sat, 1'b0);

    $display("[TB] zero length and ignored start");
    start_job(0);
    check_output("t4_done_next", bus_s.out_valid, 1);
    wait_result("t4z", e);
    finish_result("t4z", 0, e.acc_sat, 1'b1);
    check_output("t4_no_ready", ready_seen, 0);
    pair_a = '{8'd7, 8'd2};
    pair_x = '{8'd1, 8'd2};
    start_job(2);
    apply_stimulus(2, 1);
    check_output("t4_accepts", accept_cnt - acc_base, 2);
    wait_result("t4g", e);
    finish_result("t4g", 0, e.acc_sat, 1'b0);

    $display("[TB] reset mid-job");
    pair_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    pair_x = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    start_job(5);
    apply_stimulus(2, -1);
    #2 rst = 1'b1;
    #1;
    check_output("t5_in_ready", bus_s.in_ready, 0);
    check_output("t5_out_valid", bus_s.out_valid, 0);
    check_output("t5_busy", bus_s.busy, 0);
    check_output("t5_acc", bus_s.acc_out, 0);
    check_output("t5_sat", bus_s.sat_flag, 0);
    check_output("t5_mult_a", bus_s.mult_a, 0);
    check_output("t5_mult_x", bus_s.mult_x, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    pair_a = '{8'd2};
    pair_x = '{8'd3};
    start_job(1);
    apply_stimulus(1, -1);
    wait_result("t5", e);
    check_output("t5_const", bus_s.acc_out, 5);
    finish_result("t5", 0, e.acc_sat, 1'b0);

    $display("[TB] real multiplier");
    use_real = 1'b1;
    pair_a = '{8'h7F, 8'h81};
    pair_x = '{8'h40, 8'h40};
    start_job(2);
    apply_stimulus(2, -1);
    wait_result("t6", e);
    v = int'($signed(bus_s.acc_out));
    check_output("t6_cancel", (v <= 1 && v >= -1), 1);
    finish_result("t6", 0, e.acc_sat, 1'b0);
    use_real = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
